// File: rtl/extreme_val_update_pkg.sv
// Shared definitions for the extreme-value feature record: field offsets,
// record layout and small helpers used by the cache, update stage and classifier.
package extreme_val_update_pkg;

   // Record geometry
   localparam int REC_W        = 192;
   localparam int VEC_W        = 160;
   localparam int FLD_W        = 8;

   // Bit offsets of each field inside the 192-bit record
   localparam int VEC_LSB      = 32;
   localparam int MAX_SIZE_LSB = 24;
   localparam int MIN_SIZE_LSB = 16;
   localparam int MAX_ARIT_LSB = 8;
   localparam int MIN_ARIT_LSB = 0;

   // Packed view of the record; declaration order gives the offsets above
   // (first member is the most significant).
   typedef struct packed {
      logic [VEC_W-1:0] vec;
      logic [FLD_W-1:0] max_size;
      logic [FLD_W-1:0] min_size;
      logic [FLD_W-1:0] max_arit;
      logic [FLD_W-1:0] min_arit;
   } feat_rec_t;

   // Flat vector -> structured record
   function automatic feat_rec_t rec_unpack(input logic [REC_W-1:0] flat);
      feat_rec_t rec;
      rec.vec      = flat[VEC_LSB      +: VEC_W];
      rec.max_size = flat[MAX_SIZE_LSB +: FLD_W];
      rec.min_size = flat[MIN_SIZE_LSB +: FLD_W];
      rec.max_arit = flat[MAX_ARIT_LSB +: FLD_W];
      rec.min_arit = flat[MIN_ARIT_LSB +: FLD_W];
      return rec;
   endfunction

   // Structured record -> flat vector
   function automatic logic [REC_W-1:0] rec_pack(input feat_rec_t rec);
      logic [REC_W-1:0] flat;
      flat                          = '0;
      flat[VEC_LSB      +: VEC_W]   = rec.vec;
      flat[MAX_SIZE_LSB +: FLD_W]   = rec.max_size;
      flat[MIN_SIZE_LSB +: FLD_W]   = rec.min_size;
      flat[MAX_ARIT_LSB +: FLD_W]   = rec.max_arit;
      flat[MIN_ARIT_LSB +: FLD_W]   = rec.min_arit;
      return flat;
   endfunction

   // Unsigned 8-bit max; ties return the stored value unchanged
   function automatic logic [FLD_W-1:0] max8(input logic [FLD_W-1:0] stored,
                                              input logic [FLD_W-1:0] sample);
      return (sample > stored) ? sample : stored;
   endfunction

   // Unsigned 8-bit min; ties return the stored value unchanged
   function automatic logic [FLD_W-1:0] min8(input logic [FLD_W-1:0] stored,
                                              input logic [FLD_W-1:0] sample);
      return (sample < stored) ? sample : stored;
   endfunction

endpackage

// File: rtl/extreme_val_fwd_hist.sv
// Write history used to forward in-flight results to the merge slot.
// Entry 0 is the write being presented this cycle (driven straight from the
// parent's write register); entries 1..HIST-1 are the previous valid writes,
// youngest first. The lookup returns the youngest entry whose address matches.
module extreme_val_fwd_hist
   import extreme_val_update_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int HIST   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_v,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [REC_W-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_lkp_addr,
   output logic              o_hit,
   output logic [REC_W-1:0]  o_data
);

   // Older entries (index 1 = most recent write before the current one)
   logic              r_v    [1:HIST-1];
   logic [ADDR_W-1:0] r_addr [1:HIST-1];
   logic [REC_W-1:0]  r_data [1:HIST-1];

   // Full view of the history including entry 0
   logic              w_v    [HIST];
   logic [ADDR_W-1:0] w_addr [HIST];
   logic [REC_W-1:0]  w_data [HIST];

   // Assemble the full history view, current write in slot 0
   always_comb begin
      w_v[0]    = i_wr_v;
      w_addr[0] = i_wr_addr;
      w_data[0] = i_wr_data;
      for (int k = 1; k < HIST; k++) begin
         w_v[k]    = r_v[k];
         w_addr[k] = r_addr[k];
         w_data[k] = r_data[k];
      end
   end

   // Age the history by one slot whenever a valid write is presented
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 1; k < HIST; k++) begin
            r_v[k]    <= 1'b0;
            r_addr[k] <= '0;
            r_data[k] <= '0;
         end
      end else if (i_wr_v) begin
         for (int k = 1; k < HIST; k++) begin
            r_v[k]    <= w_v[k-1];
            r_addr[k] <= w_addr[k-1];
            r_data[k] <= w_data[k-1];
         end
      end
   end

   // Youngest-match mux: scan oldest to youngest so the youngest hit overrides
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      for (int k = HIST-1; k >= 0; k--) begin
         if (w_v[k] && (w_addr[k] == i_lkp_addr)) begin
            o_hit  = 1'b1;
            o_data = w_data[k];
         end
      end
   end

endmodule

// File: rtl/extreme_val_update.sv
// Read-modify-write stage behind the extreme-value cache. A packet descriptor
// accepted in cycle T issues a cache read in T+1, meets the returned history
// in the merge slot at T+1+RD_LAT, and its updated record is written back and
// presented to the classifier at T+2+RD_LAT. Same-flow hazards are covered by
// forwarding from the write history, so the stage never stalls.
//
// Valid semantics: pkt_v, rd_mem, i_rd_data_v, wea and o_upd_v are
// single-cycle qualifiers with no ready/backpressure; the payload beside a
// valid is meaningful only in the cycle the valid is 1. i_rd_data_v must
// arrive exactly RD_LAT cycles after rd_mem; any disagreement latches
// o_sync_err, and the merge is driven by the stage's own context valid.
module extreme_val_update
   import extreme_val_update_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 2,
   parameter int HIST   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // packet descriptors
   input  logic              pkt_v,
   input  logic              pkt_first,
   input  logic [ADDR_W-1:0] pkt_flow_id,
   input  logic [7:0]        pkt_size,
   input  logic [7:0]        pkt_arit,
   input  logic [159:0]      pkt_vec,
   // cache read port
   output logic              rd_mem,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        i_max_pkt_size,
   input  logic [7:0]        i_min_pkt_size,
   input  logic [7:0]        i_max_pkt_arit,
   input  logic [7:0]        i_min_pkt_arit,
   input  logic [159:0]      i_vec_feature,
   input  logic              i_rd_data_v,
   // cache write-back port
   output logic [ADDR_W-1:0] wr_addr,
   output logic [191:0]      wr_data,
   output logic              wea,
   // classifier feed
   output logic              o_upd_v,
   output logic [ADDR_W-1:0] o_flow_id,
   output logic [191:0]      o_feature,
   output logic              o_sync_err
);

   // Per-packet context carried alongside the cache read
   typedef struct packed {
      logic              first;
      logic [ADDR_W-1:0] flow_id;
      logic [7:0]        size;
      logic [7:0]        arit;
      logic [VEC_W-1:0]  vec;
   } ctx_t;

   localparam int DEPTH = RD_LAT + 1;

   // Read issue registers
   logic              r_rd_mem;
   logic [ADDR_W-1:0] r_rd_addr;

   // Context shift pipe; the last stage is the merge slot
   logic              r_ctx_v [DEPTH];
   ctx_t              r_ctx   [DEPTH];

   // Write-back / classifier register
   logic              r_wea;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [REC_W-1:0]  r_wr_data;

   logic              r_sync_err;

   // Combinational signals
   ctx_t              w_pkt_ctx;
   logic              w_slot_v;
   ctx_t              w_slot;
   logic              w_fwd_hit;
   logic [REC_W-1:0]  w_fwd_data;
   feat_rec_t         w_base;
   feat_rec_t         w_merged;

   // Bundle the incoming descriptor into a context word
   always_comb begin
      w_pkt_ctx         = '0;
      w_pkt_ctx.first   = pkt_first;
      w_pkt_ctx.flow_id = pkt_flow_id;
      w_pkt_ctx.size    = pkt_size;
      w_pkt_ctx.arit    = pkt_arit;
      w_pkt_ctx.vec     = pkt_vec;
   end

   // Issue the cache read one cycle after the descriptor is sampled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_mem  <= 1'b0;
         r_rd_addr <= '0;
      end else begin
         r_rd_mem <= pkt_v;
         if (pkt_v) begin
            r_rd_addr <= pkt_flow_id;
         end
      end
   end

   // Carry packet context alongside the read for RD_LAT+1 cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < DEPTH; s++) begin
            r_ctx_v[s] <= 1'b0;
            r_ctx[s]   <= '0;
         end
      end else begin
         r_ctx_v[0] <= pkt_v;
         if (pkt_v) begin
            r_ctx[0] <= w_pkt_ctx;
         end
         for (int s = 1; s < DEPTH; s++) begin
            r_ctx_v[s] <= r_ctx_v[s-1];
            if (r_ctx_v[s-1]) begin
               r_ctx[s] <= r_ctx[s-1];
            end
         end
      end
   end

   assign w_slot_v = r_ctx_v[DEPTH-1];
   assign w_slot   = r_ctx[DEPTH-1];

   // Forwarding history; entry 0 is the write register presented this cycle
   extreme_val_fwd_hist #(
      .ADDR_W (ADDR_W),
      .HIST   (HIST)
   ) u_fwd_hist (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_v     (r_wea),
      .i_wr_addr  (r_wr_addr),
      .i_wr_data  (r_wr_data),
      .i_lkp_addr (w_slot.flow_id),
      .o_hit      (w_fwd_hit),
      .o_data     (w_fwd_data)
   );

   // Pick the base record (forwarded write wins over the cache) and merge
   always_comb begin
      w_base   = '0;
      w_merged = '0;
      if (w_fwd_hit) begin
         w_base = rec_unpack(w_fwd_data);
      end else begin
         w_base.vec      = i_vec_feature;
         w_base.max_size = i_max_pkt_size;
         w_base.min_size = i_min_pkt_size;
         w_base.max_arit = i_max_pkt_arit;
         w_base.min_arit = i_min_pkt_arit;
      end
      w_merged.vec = w_slot.vec;
      if (w_slot.first) begin
         w_merged.max_size = w_slot.size;
         w_merged.min_size = w_slot.size;
         w_merged.max_arit = w_slot.arit;
         w_merged.min_arit = w_slot.arit;
      end else begin
         w_merged.max_size = max8(w_base.max_size, w_slot.size);
         w_merged.min_size = min8(w_base.min_size, w_slot.size);
         w_merged.max_arit = max8(w_base.max_arit, w_slot.arit);
         w_merged.min_arit = min8(w_base.min_arit, w_slot.arit);
      end
   end

   // Register the merged record for write-back; bubbles only drop the strobe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wea     <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wea <= w_slot_v;
         if (w_slot_v) begin
            r_wr_addr <= w_slot.flow_id;
            r_wr_data <= rec_pack(w_merged);
         end
      end
   end

   // Latch any disagreement between returned data valid and the merge slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync_err <= 1'b0;
      end else if (w_slot_v != i_rd_data_v) begin
         r_sync_err <= 1'b1;
      end
   end

   assign rd_mem     = r_rd_mem;
   assign rd_addr    = r_rd_addr;
   assign wea        = r_wea;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign o_upd_v    = r_wea;
   assign o_flow_id  = r_wr_addr;
   assign o_feature  = r_wr_data;
   assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_extreme_val_update.sv
// Bench for extreme_val_update: cache model with fixed read latency, a
// sequential reference of the per-flow records, and a per-cycle scoreboard.
module tb_extreme_val_update;
   localparam int ADDR_W = 12;
   localparam int RD_LAT = 2;
   localparam int HIST   = 4;
   localparam int REC_W  = 192;
   localparam int QW     = 32 + ADDR_W + REC_W;
   localparam int NFLOW  = 1 << ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              pkt_v, pkt_first;
   logic [ADDR_W-1:0] pkt_flow_id;
   logic [7:0]        pkt_size, pkt_arit;
   logic [159:0]      pkt_vec;
   logic              rd_mem;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        i_max_pkt_size, i_min_pkt_size, i_max_pkt_arit, i_min_pkt_arit;
   logic [159:0]      i_vec_feature;
   logic              i_rd_data_v;
   logic [ADDR_W-1:0] wr_addr;
   logic [191:0]      wr_data;
   logic              wea;
   logic              o_upd_v;
   logic [ADDR_W-1:0] o_flow_id;
   logic [191:0]      o_feature;
   logic              o_sync_err;

   extreme_val_update #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .HIST(HIST)) dut (
      .clk(clk), .rst_n(rst_n),
      .pkt_v(pkt_v), .pkt_first(pkt_first), .pkt_flow_id(pkt_flow_id),
      .pkt_size(pkt_size), .pkt_arit(pkt_arit), .pkt_vec(pkt_vec),
      .rd_mem(rd_mem), .rd_addr(rd_addr),
      .i_max_pkt_size(i_max_pkt_size), .i_min_pkt_size(i_min_pkt_size),
      .i_max_pkt_arit(i_max_pkt_arit), .i_min_pkt_arit(i_min_pkt_arit),
      .i_vec_feature(i_vec_feature), .i_rd_data_v(i_rd_data_v),
      .wr_addr(wr_addr), .wr_data(wr_data), .wea(wea),
      .o_upd_v(o_upd_v), .o_flow_id(o_flow_id), .o_feature(o_feature),
      .o_sync_err(o_sync_err)
   );

   // Initial cache contents (some flows hold deliberately stale values)
   function automatic logic [REC_W-1:0] init_rec(input int a);
      logic [159:0] v;
      v = {5{32'(a) ^ 32'hA5A5_0000}};
      case (a)
         1:       return {v, 8'd100, 8'd50,  8'd60,  8'd30};
         2:       return {v, 8'd150, 8'd120, 8'd9,   8'd5};
         7:       return {v, 8'd200, 8'd1,   8'd200, 8'd1};
         default: return {v, 8'd128, 8'd128, 8'd128, 8'd128};
      endcase
   endfunction

   // ---------------- cache model ----------------
   logic [REC_W-1:0] cache_mem [NFLOW];
   logic             cache_init = 1'b0;
   logic             rd_v0 = 1'b0, rd_v1 = 1'b0;
   logic [REC_W-1:0] rd_d0 = '0, rd_d1 = '0;
   logic             drop_arm;
   logic             dropped = 1'b0;

   // Cache storage with write-back and an RD_LAT (=2) cycle read pipeline
   always @(posedge clk) begin
      if (!cache_init) begin
         for (int a = 0; a < NFLOW; a++) cache_mem[a] <= init_rec(a);
         cache_init <= 1'b1;
      end else if (wea) begin
         cache_mem[wr_addr] <= wr_data;
      end
      if (!rst_n) begin
         rd_v0 <= 1'b0;
         rd_v1 <= 1'b0;
      end else begin
         rd_v0 <= rd_mem && !(drop_arm && !dropped);
         if (rd_mem && drop_arm && !dropped) dropped <= 1'b1;
         rd_d0 <= cache_mem[rd_addr];
         rd_v1 <= rd_v0;
         rd_d1 <= rd_d0;
      end
   end

   assign i_rd_data_v    = rd_v1;
   assign i_vec_feature  = rd_d1[191:32];
   assign i_max_pkt_size = rd_d1[31:24];
   assign i_min_pkt_size = rd_d1[23:16];
   assign i_max_pkt_arit = rd_d1[15:8];
   assign i_min_pkt_arit = rd_d1[7:0];

   // ---------------- reference model / scoreboard ----------------
   logic [REC_W-1:0]        ref_mem [NFLOW];
   logic [QW-1:0]           exp_q[$];
   logic [ADDR_W+REC_W-1:0] wr_log[$];
   int                      n_checks = 0;
   int                      n_err    = 0;
   int                      cyc      = 0;
   logic [159:0]            last_vec;

   // Sequential semantics: each packet updates the latest record of its flow
   function automatic logic [REC_W-1:0] ref_merge(input logic [REC_W-1:0] base, input bit first,
                                                  input int sz, input int ar, input logic [159:0] vec);
      int mx_s, mn_s, mx_a, mn_a;
      if (first) begin
         mx_s = sz; mn_s = sz; mx_a = ar; mn_a = ar;
      end else begin
         mx_s = (sz > int'(base[31:24])) ? sz : int'(base[31:24]);
         mn_s = (sz < int'(base[23:16])) ? sz : int'(base[23:16]);
         mx_a = (ar > int'(base[15:8]))  ? ar : int'(base[15:8]);
         mn_a = (ar < int'(base[7:0]))   ? ar : int'(base[7:0]);
      end
      return {vec, 8'(mx_s), 8'(mn_s), 8'(mx_a), 8'(mn_a)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Advance one cycle and run the per-cycle output comparison
   task automatic tick();
      logic [QW-1:0] e;
      int            e_cyc;
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         n_checks++;
         if (o_upd_v !== wea || o_flow_id !== wr_addr || o_feature !== wr_data) begin
            n_err++;
            $display("FAIL upd_mirror upd_v=%b flow=%0h wea=%b wr_addr=%0h", o_upd_v, o_flow_id, wea, wr_addr);
         end
         if (wea === 1'b1) begin
            wr_log.push_back({wr_addr, wr_data});
            n_checks++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write cyc=%0d addr=%0h data=%h", cyc, wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               e_cyc = int'(e[QW-1 -: 32]);
               if (wr_addr !== e[REC_W +: ADDR_W] || wr_data !== e[REC_W-1:0] || cyc != e_cyc) begin
                  n_err++;
                  $display("FAIL write cyc=%0d/%0d addr=%0h/%0h data=%h required=%h",
                           cyc, e_cyc, wr_addr, e[REC_W +: ADDR_W], wr_data, e[REC_W-1:0]);
               end
            end
         end else if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (int'(e[QW-1 -: 32]) <= cyc) begin
               e = exp_q.pop_front();
               n_checks++;
               n_err++;
               $display("FAIL missing_write cyc=%0d addr=%0h", cyc, e[REC_W +: ADDR_W]);
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input bit first, input int flow, input int sz, input int ar);
      logic [REC_W-1:0] rec;
      logic [159:0]     vec;
      vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
      last_vec = vec;
      rec = ref_merge(ref_mem[flow], first, sz, ar, vec);
      ref_mem[flow] = rec;
      exp_q.push_back({32'(cyc + 4), ADDR_W'(flow), rec});
      pkt_v = 1'b1; pkt_first = first; pkt_flow_id = ADDR_W'(flow);
      pkt_size = 8'(sz); pkt_arit = 8'(ar); pkt_vec = vec;
      tick();
      pkt_v = 1'b0;
      chk("rd_strobe", {rd_mem, rd_addr}, {1'b1, ADDR_W'(flow)});
   endtask

   task automatic idle(input int n);
      pkt_v = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         chk("rd_idle", rd_mem, 1'b0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
      chk("drain", exp_q.size(), 0);
      idle(2);
   endtask

   function automatic logic [REC_W-1:0] log_data(input int i);
      logic [ADDR_W+REC_W-1:0] x;
      x = wr_log[i];
      return x[REC_W-1:0];
   endfunction

   function automatic logic [ADDR_W-1:0] log_addr(input int i);
      logic [ADDR_W+REC_W-1:0] x;
      x = wr_log[i];
      return x[REC_W +: ADDR_W];
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [REC_W-1:0] d;
      logic [REC_W-1:0] saved [3];
      for (int a = 0; a < NFLOW; a++) ref_mem[a] = init_rec(a);
      rst_n = 1'b0; drop_arm = 1'b0;
      pkt_v = 1'b0; pkt_first = 1'b0; pkt_flow_id = '0;
      pkt_size = '0; pkt_arit = '0; pkt_vec = '0;
      repeat (3) tick();
      chk("reset_ctrl", {rd_mem, wea, o_upd_v, o_sync_err}, 4'b0);
      chk("reset_addr", {rd_addr, wr_addr, o_flow_id}, '0);
      chk("reset_data", {63'd0, (|wr_data) | (|o_feature)}, 0);
      rst_n = 1'b1;
      idle(2);

      // Single first packet
      wr_log.delete();
      send(1, 5, 40, 10);
      drain();
      chk("t1_count", wr_log.size(), 1);
      d = log_data(0);
      chk("t1_addr", log_addr(0), 5);
      chk("t1_fields", d[31:0], 32'h2828_0A0A);
      chk("t1_vec_lo", d[95:32], last_vec[63:0]);
      idle(3);

      // Second packet of flow 5 merges against the stored record
      wr_log.delete();
      send(0, 5, 90, 3);
      drain();
      d = log_data(0);
      chk("t2_fields", d[31:0], 32'h5A28_0A03);

      // Back-to-back on flow 7 over stale cache contents
      wr_log.delete();
      send(1, 7, 50, 10);
      send(0, 7, 20, 10);
      send(0, 7, 80, 10);
      send(0, 7, 60, 10);
      drain();
      chk("t3_count", wr_log.size(), 4);
      d = log_data(0); chk("t3_w0", d[31:16], 16'h3232);
      d = log_data(1); chk("t3_w1", d[31:16], 16'h3214);
      d = log_data(2); chk("t3_w2", d[31:16], 16'h5014);
      d = log_data(3); chk("t3_w3", d[31:16], 16'h5014);

      // Interleaved flows 1,2,1,2
      wr_log.delete();
      send(0, 1, 200, 40);
      send(0, 2, 130, 40);
      send(0, 1, 10,  40);
      send(0, 2, 250, 40);
      drain();
      d = log_data(0); chk("t4_w0", d[31:16], 16'hC832);
      d = log_data(1); chk("t4_w1", d[31:16], 16'h9678);
      d = log_data(2); chk("t4_w2", d[31:16], 16'hC80A);
      d = log_data(3); chk("t4_w3", d[31:16], 16'hFA78);

      // Dropped read-data valid
      chk("sync_before", o_sync_err, 1'b0);
      drop_arm = 1'b1;
      send(0, 5, 17, 200);
      drain();
      chk("sync_set", o_sync_err, 1'b1);
      idle(5);
      chk("sync_sticky", o_sync_err, 1'b1);

      // Reset with three packets in flight
      for (int i = 0; i < 3; i++) saved[i] = ref_mem[20 + i];
      send(1, 20, 1, 2);
      send(1, 21, 3, 4);
      send(1, 22, 5, 6);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         void'(exp_q.pop_back());
         ref_mem[20 + i] = saved[i];
      end
      chk("rst_ctrl", {rd_mem, wea, o_upd_v, o_sync_err}, 4'b0);
      chk("rst_addr", {rd_addr, wr_addr, o_flow_id}, '0);
      chk("rst_data", {63'd0, (|wr_data) | (|o_feature)}, 0);
      wr_log.delete();
      idle(8);
      chk("rst_no_write", wr_log.size(), 0);
      send(1, 9, 33, 44);
      drain();
      chk("rst_new_pkt", wr_log.size(), 1);

      // Randomized traffic over a small flow set to provoke hazards
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0)
            send($urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
         else
            idle(1);
      end
      drain();
      chk("sync_clean", o_sync_err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
